// File: rtl/load_align_unit.sv
// -----------------------------------------------------------------------------
// load_align_unit
//
// Load-path unit between the MEM stage and the word-organised data RAM. It
// accepts one load request at a time and issues a single word-aligned read. It
// then waits for the read data, with a timeout. It extracts the addressed byte
// or halfword, sign- or zero-extends it, and returns the result to writeback
// over a valid/ready handshake.
//
// Optional feature: define LOAD_MISALIGN_CHK_EN to turn misaligned LH/LHU/LW
// accesses into immediate error responses. No read is issued for them.
//
// Parameters:
//   MAX_WAIT    WAIT cycles without mem_rvalid before a timeout (1..255)
// Ports:
//   cpu_clk     clock, rising edge
//   cpu_rstn    synchronous active-low reset
//   req_valid   load request present
//   req_ready   unit idle and out of reset, request can be accepted
//   req_addr    byte address
//   req_op      funct3 load type (LB/LH/LW/LBU/LHU)
//   req_rd      destination register tag
//   mem_re      one-cycle read strobe
//   mem_addr    word-aligned read address
//   mem_rvalid  read data valid
//   mem_rdata   read word
//   resp_valid  response valid
//   resp_ready  response accepted by consumer
//   resp_data   extended load result
//   resp_rd     destination tag of the response
//   resp_err    illegal op, timeout or (optionally) misaligned access
//   busy        unit not idle (pipeline stall)
// -----------------------------------------------------------------------------
module load_align_unit #(
    parameter int MAX_WAIT = 15
) (
    input  logic        cpu_clk,
    input  logic        cpu_rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_op,
    input  logic [4:0]  req_rd,
    output logic        mem_re,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_err,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LH  = 3'b001,
        OP_LW  = 3'b010,
        OP_LBU = 3'b100,
        OP_LHU = 3'b101
    } load_op_t;

    // Value of the wait counter during the last WAIT cycle before a timeout.
    localparam logic [7:0] LP_WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_addr;
    logic [2:0]  r_op;
    logic [4:0]  r_rd;
    logic [7:0]  r_wait;
    logic [31:0] r_data;
    logic        r_err;

    logic        w_accept;
    logic        w_req_bad;
    logic        w_timeout;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_extract;

    assign w_accept  = req_valid && (r_state == S_IDLE) && cpu_rstn;
    assign w_timeout = (r_wait == LP_WAIT_LAST);

    // A request is rejected on the spot for an illegal op. With the misalign
    // check enabled, a misaligned access is rejected as well.
    always_comb begin
        w_req_bad = !(req_op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU});
`ifdef LOAD_MISALIGN_CHK_EN
        if ((req_op == OP_LH || req_op == OP_LHU) && req_addr[0])
            w_req_bad = 1'b1;
        if (req_op == OP_LW && req_addr[1:0] != 2'b00)
            w_req_bad = 1'b1;
`endif
    end

    // Lane selection works from the latched byte address. Halfword lanes use
    // only addr[1], so an odd halfword address falls back to its aligned half.
    always_comb begin
        w_byte    = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
        w_half    = mem_rdata[{r_addr[1], 4'b0000} +: 16];
        w_extract = 32'h0;
        case (r_op)
            OP_LB:   w_extract = {{24{w_byte[7]}}, w_byte};
            OP_LH:   w_extract = {{16{w_half[15]}}, w_half};
            OP_LW:   w_extract = mem_rdata;
            OP_LBU:  w_extract = {24'h0, w_byte};
            OP_LHU:  w_extract = {16'h0, w_half};
            default: w_extract = 32'h0;
        endcase
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path through it can leave a signal unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        req_ready    = (r_state == S_IDLE) && cpu_rstn;
        mem_re       = (r_state == S_REQ);
        resp_valid   = (r_state == S_RESP);
        busy         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: if (w_accept) w_next_state = w_req_bad ? S_RESP : S_REQ;
            S_REQ:  w_next_state = S_WAIT;
            S_WAIT: if (mem_rvalid || w_timeout) w_next_state = S_RESP;
            S_RESP: if (resp_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: reset is sampled on the clock edge, so it sits inside the clocked
    // block rather than in its sensitivity list.
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rstn) begin
            r_addr <= 32'h0;
            r_op   <= 3'b000;
            r_rd   <= 5'h0;
            r_wait <= 8'h0;
            r_data <= 32'h0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr <= req_addr;
                        r_op   <= req_op;
                        r_rd   <= req_rd;
                        r_wait <= 8'h0;
                        r_data <= 32'h0;
                        r_err  <= w_req_bad;
                    end
                end
                S_WAIT: begin
                    // Data arriving in the final WAIT cycle beats the timeout.
                    if (mem_rvalid) begin
                        r_data <= w_extract;
                        r_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_data <= 32'h0;
                        r_err  <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = {r_addr[31:2], 2'b00};
    assign resp_data = r_data;
    assign resp_rd   = r_rd;
    assign resp_err  = r_err;

endmodule

// File: tb/tb_load_align_unit.sv
// -----------------------------------------------------------------------------
// tb_load_align_unit
//
// Self-checking bench for load_align_unit. Directed scenarios come from the
// unit's documented behaviour, and a randomized pass is checked against a
// behavioural load model. Inputs are driven and outputs sampled on the falling
// clock edge.
// -----------------------------------------------------------------------------
module tb_load_align_unit;

    localparam int MAX_WAIT = 15;

    logic        cpu_clk;
    logic        cpu_rstn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_op;
    logic [4:0]  req_rd;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic        busy;

    int errors = 0;
    int checks = 0;

    load_align_unit #(.MAX_WAIT(MAX_WAIT)) dut (
        .cpu_clk   (cpu_clk),
        .cpu_rstn  (cpu_rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_op    (req_op),
        .req_rd    (req_rd),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .resp_rd   (resp_rd),
        .resp_err  (resp_err),
        .busy      (busy)
    );

    initial begin
        cpu_clk = 1'b0;
        forever #5 cpu_clk = ~cpu_clk;
    end

    // Behavioural load model: lane extraction uses shifts and masks, and
    // sign extension uses a two's-complement subtraction.
    function automatic void model(input logic [2:0] op, input logic [31:0] addr,
                                  input logic [31:0] rdata, output logic imm,
                                  output logic [31:0] data);
        logic [31:0] b;
        logic [31:0] h;
        b    = (rdata >> (8 * int'(addr[1:0]))) & 32'hFF;
        h    = (rdata >> (16 * int'(addr[1]))) & 32'hFFFF;
        imm  = 1'b0;
        data = 32'h0;
        case (op)
            3'd0: data = (b >= 32'd128) ? b - 32'd256 : b;
            3'd1: data = (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd2: data = rdata;
            3'd4: data = b;
            3'd5: data = h;
            default: imm = 1'b1;
        endcase
`ifdef LOAD_MISALIGN_CHK_EN
        if ((op == 3'd1 || op == 3'd5) && addr[0]) imm = 1'b1;
        if (op == 3'd2 && addr[1:0] != 2'b00) imm = 1'b1;
`endif
        if (imm) data = 32'h0;
    endfunction

    // Runs one load starting in an IDLE cycle at a falling edge and finishes
    // in the IDLE cycle after the response handshake. lat = WAIT cycles before
    // mem_rvalid (0 means the first WAIT cycle, >= MAX_WAIT means never).
    // hold = cycles resp_ready is held low in RESP.
    task automatic run_load(input string name, input logic [31:0] addr,
                            input logic [2:0] op, input logic [4:0] rd,
                            input logic [31:0] rdata, input int lat, input int hold,
                            input logic imm, input logic exp_err,
                            input logic [31:0] exp_data);
        int n_wait;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL %s idle req_ready got=%0b exp=1", name, req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s idle busy got=%0b exp=0", name, busy); end
        req_valid = 1'b1; req_addr = addr; req_op = op; req_rd = rd;
        @(negedge cpu_clk);  // T+1
        req_valid = 1'b0; req_addr = $urandom; req_op = 3'($urandom); req_rd = 5'($urandom);
        if (imm) begin
            checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL %s imm mem_re got=%0b exp=0", name, mem_re); end
        end else begin
            checks++; if (mem_re !== 1'b1) begin errors++; $display("FAIL %s req mem_re got=%0b exp=1", name, mem_re); end
            checks++; if (mem_addr !== {addr[31:2], 2'b00}) begin errors++; $display("FAIL %s req mem_addr got=%h exp=%h", name, mem_addr, {addr[31:2], 2'b00}); end
            checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL %s req resp_valid got=%0b exp=0", name, resp_valid); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s req busy got=%0b exp=1", name, busy); end
            mem_rvalid = 1'b1; mem_rdata = $urandom;  // must be ignored in REQ
            n_wait = (lat >= MAX_WAIT) ? MAX_WAIT : lat + 1;
            for (int k = 0; k < n_wait; k++) begin
                @(negedge cpu_clk);  // T+2+k, WAIT
                checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL %s wait%0d resp_valid got=%0b exp=0", name, k, resp_valid); end
                checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL %s wait%0d mem_re got=%0b exp=0", name, k, mem_re); end
                checks++; if (mem_addr !== {addr[31:2], 2'b00}) begin errors++; $display("FAIL %s wait%0d mem_addr got=%h exp=%h", name, k, mem_addr, {addr[31:2], 2'b00}); end
                checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL %s wait%0d req_ready got=%0b exp=0", name, k, req_ready); end
                mem_rvalid = (k == lat);
                mem_rdata  = (k == lat) ? rdata : $urandom;
            end
            @(negedge cpu_clk);  // first RESP cycle
        end
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge cpu_clk);
            checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL %s resp%0d resp_valid got=%0b exp=1", name, h, resp_valid); end
            checks++; if (resp_data !== exp_data) begin errors++; $display("FAIL %s resp%0d resp_data got=%h exp=%h", name, h, resp_data, exp_data); end
            checks++; if (resp_rd !== rd) begin errors++; $display("FAIL %s resp%0d resp_rd got=%0d exp=%0d", name, h, resp_rd, rd); end
            checks++; if (resp_err !== exp_err) begin errors++; $display("FAIL %s resp%0d resp_err got=%0b exp=%0b", name, h, resp_err, exp_err); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL %s resp%0d req_ready got=%0b exp=0", name, h, req_ready); end
            checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL %s resp%0d mem_re got=%0b exp=0", name, h, mem_re); end
            mem_rvalid = 1'b1; mem_rdata = $urandom;  // stale data, ignored in RESP
            resp_ready = (h == hold);
        end
        @(negedge cpu_clk);  // cycle after the handshake
        resp_ready = 1'b0;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL %s post resp_valid got=%0b exp=0", name, resp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL %s post req_ready got=%0b exp=1", name, req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s post busy got=%0b exp=0", name, busy); end
        mem_rvalid = 1'b1; mem_rdata = $urandom;  // stale data, ignored in IDLE
    endtask

    task automatic test_reset();
        cpu_rstn = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_op = 3'b000; req_rd = 5'h0;
        mem_rvalid = 1'b0; mem_rdata = 32'h0; resp_ready = 1'b0;
        repeat (3) @(negedge cpu_clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset req_ready got=%0b exp=0", req_ready); end
        checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL reset mem_re got=%0b exp=0", mem_re); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset mem_addr got=%h exp=0", mem_addr); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset resp_valid got=%0b exp=0", resp_valid); end
        checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL reset resp_data got=%h exp=0", resp_data); end
        checks++; if (resp_rd !== 5'h0) begin errors++; $display("FAIL reset resp_rd got=%0d exp=0", resp_rd); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset resp_err got=%0b exp=0", resp_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got=%0b exp=0", busy); end
        cpu_rstn = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset release req_ready got=%0b exp=1", req_ready); end
        @(negedge cpu_clk);
    endtask

    task automatic test_lb();
        run_load("lb_sign", 32'h0000_1003, 3'b000, 5'd7, 32'h80FF_1234, 0, 0, 1'b0, 1'b0, 32'hFFFF_FF80);
    endtask

    task automatic test_lhu_backpressure();
        run_load("lhu_hold", 32'h0000_2002, 3'b101, 5'd12, 32'h8001_7FFF, 0, 4, 1'b0, 1'b0, 32'h0000_8001);
    endtask

    task automatic test_timeout();
        // Never answered; stale rvalid keeps arriving during the held RESP.
        run_load("lw_timeout", 32'h0000_3000, 3'b010, 5'd3, 32'h0, MAX_WAIT + 5, 4, 1'b0, 1'b1, 32'h0);
    endtask

    task automatic test_data_wins();
        run_load("data_wins", 32'h0000_6001, 3'b100, 5'd9, 32'h0000_C300, MAX_WAIT - 1, 0, 1'b0, 1'b0, 32'h0000_00C3);
    endtask

    task automatic test_illegal();
        run_load("illegal_011", 32'h0000_0040, 3'b011, 5'd1, 32'h0, 0, 1, 1'b1, 1'b1, 32'h0);
        run_load("illegal_111", 32'h0000_0044, 3'b111, 5'd2, 32'h0, 0, 0, 1'b1, 1'b1, 32'h0);
    endtask

    task automatic test_misalign();
`ifdef LOAD_MISALIGN_CHK_EN
        run_load("lh_misalign", 32'h0000_4001, 3'b001, 5'd4, 32'h1234_ABCD, 0, 0, 1'b1, 1'b1, 32'h0);
        run_load("lw_misalign", 32'h0000_5003, 3'b010, 5'd5, 32'hDEAD_BEEF, 0, 0, 1'b1, 1'b1, 32'h0);
`else
        run_load("lh_misalign", 32'h0000_4001, 3'b001, 5'd4, 32'h1234_ABCD, 0, 0, 1'b0, 1'b0, 32'hFFFF_ABCD);
        run_load("lw_misalign", 32'h0000_5003, 3'b010, 5'd5, 32'hDEAD_BEEF, 2, 0, 1'b0, 1'b0, 32'hDEAD_BEEF);
`endif
    endtask

    task automatic test_back_to_back();
        run_load("b2b_lbu", 32'h0000_0011, 3'b100, 5'd20, 32'h0000_F700, 1, 0, 1'b0, 1'b0, 32'h0000_00F7);
        run_load("b2b_lh", 32'h0000_0002, 3'b001, 5'd21, 32'h9ABC_0000, 0, 0, 1'b0, 1'b0, 32'hFFFF_9ABC);
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_addr = 32'h0000_7000; req_op = 3'b010; req_rd = 5'd30;
        @(negedge cpu_clk);  // REQ
        req_valid = 1'b0; mem_rvalid = 1'b0;
        @(negedge cpu_clk);  // WAIT
        @(negedge cpu_clk);  // WAIT
        cpu_rstn = 1'b0;
        @(negedge cpu_clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid busy got=%0b exp=0", busy); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid resp_valid got=%0b exp=0", resp_valid); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mid mem_addr got=%h exp=0", mem_addr); end
        cpu_rstn = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;  // stale answer to the abandoned read
        @(negedge cpu_clk);
        mem_rvalid = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid stale busy got=%0b exp=0", busy); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid stale resp_valid got=%0b exp=0", resp_valid); end
        run_load("rst_mid_lw", 32'h0000_7004, 3'b010, 5'd31, 32'hCAFE_F00D, 1, 0, 1'b0, 1'b0, 32'hCAFE_F00D);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] exp_data;
        logic [2:0]  op;
        logic        imm;
        logic        err;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            addr  = $urandom;
            rdata = $urandom;
            op    = 3'($urandom_range(0, 7));
            lat   = $urandom_range(0, MAX_WAIT + 1);
            model(op, addr, rdata, imm, exp_data);
            err = imm;
            if (!imm && lat >= MAX_WAIT) begin
                err = 1'b1;
                exp_data = 32'h0;
            end
            run_load($sformatf("rand%0d", i), addr, op, 5'($urandom), rdata, lat,
                     $urandom_range(0, 3), imm, err, exp_data);
        end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_lhu_backpressure();
        test_timeout();
        test_data_wins();
        test_illegal();
        test_misalign();
        test_back_to_back();
        test_reset_mid();
        test_random();
        mem_rvalid = 1'b0;
        repeat (2) @(negedge cpu_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
